// File: rtl/grf_wb_pkg.sv
// Shared definitions for the write-back register file: write-data source
// encodings, link offset and register-file geometry.
package grf_wb_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ADDR_W   = 5;

  // Return address for link writes is the PC of the linking instruction plus 8.
  localparam logic [DATA_W-1:0] LINK_OFFSET = 32'd8;

  typedef enum logic [1:0] {
    WD_ALU  = 2'd0,
    WD_MEM  = 2'd1,
    WD_LINK = 2'd2,
    WD_RSVD = 2'd3
  } wd_type_e;

endpackage

// File: rtl/wd_mux.sv
// Write-data source select for the register file write port.
module wd_mux
  import grf_wb_pkg::*;
(
  input  logic [1:0]        wd_type,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_pc,
  output logic [DATA_W-1:0] wd,
  output logic              wd_ok
);

  // Pick the write data; the reserved encoding is flagged so the write is dropped.
  always_comb begin
    wd    = '0;
    wd_ok = 1'b1;
    case (wd_type_e'(wd_type))
      WD_ALU:  wd = alu_res;
      WD_MEM:  wd = mem_data;
      WD_LINK: wd = wb_pc + LINK_OFFSET;
      default: wd_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/grf_wb.sv
// General register file with write-back bypass, debug read port,
// registered commit trace and committed-write counter.
module grf_wb
  import grf_wb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [1:0]        wd_type,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] wb_pc,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              trc_valid,
  output logic [DATA_W-1:0] trc_pc,
  output logic [ADDR_W-1:0] trc_addr,
  output logic [DATA_W-1:0] trc_data,
  output logic [DATA_W-1:0] wr_count
);

  logic [DATA_W-1:0] wd;
  logic              wd_ok;
  logic              commit;

  logic [DATA_W-1:0] regs_q [1:NUM_REGS-1];
  logic [DATA_W-1:0] regs_d [1:NUM_REGS-1];
  logic              trc_valid_q, trc_valid_d;
  logic [DATA_W-1:0] trc_pc_q,    trc_pc_d;
  logic [ADDR_W-1:0] trc_addr_q,  trc_addr_d;
  logic [DATA_W-1:0] trc_data_q,  trc_data_d;
  logic [DATA_W-1:0] wr_count_q,  wr_count_d;

  wd_mux u_wd_mux (
    .wd_type  (wd_type),
    .alu_res  (alu_res),
    .mem_data (mem_data),
    .wb_pc    (wb_pc),
    .wd       (wd),
    .wd_ok    (wd_ok)
  );

  // A commit needs reset released, a non-zero target and a valid source;
  // gating on reset also disables the bypass while reset is held.
  always_comb begin
    commit = reset && we && (addr != '0) && wd_ok;
  end

  // Read ports: r0 and reset read zero, pending commit bypasses onto rd1/rd2.
  always_comb begin
    rd1      = '0;
    rd2      = '0;
    dbg_data = '0;
    if (reset) begin
      if (ra1 != '0) rd1 = (commit && ra1 == addr) ? wd : regs_q[ra1];
      if (ra2 != '0) rd2 = (commit && ra2 == addr) ? wd : regs_q[ra2];
      if (dbg_addr != '0) dbg_data = regs_q[dbg_addr];
    end
  end

  // Next-state for storage, trace record and commit counter.
  always_comb begin
    regs_d      = regs_q;
    trc_valid_d = commit;
    trc_pc_d    = trc_pc_q;
    trc_addr_d  = trc_addr_q;
    trc_data_d  = trc_data_q;
    wr_count_d  = wr_count_q;
    if (commit) begin
      regs_d[addr] = wd;
      trc_pc_d     = wb_pc;
      trc_addr_d   = addr;
      trc_data_d   = wd;
      wr_count_d   = wr_count_q + 32'd1;
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
      trc_valid_q <= 1'b0;
      trc_pc_q    <= '0;
      trc_addr_q  <= '0;
      trc_data_q  <= '0;
      wr_count_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      trc_valid_q <= trc_valid_d;
      trc_pc_q    <= trc_pc_d;
      trc_addr_q  <= trc_addr_d;
      trc_data_q  <= trc_data_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign trc_valid = trc_valid_q;
  assign trc_pc    = trc_pc_q;
  assign trc_addr  = trc_addr_q;
  assign trc_data  = trc_data_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_grf_wb.sv
// Self-checking bench for grf_wb against a behavioural register-file model.
module tb_grf_wb;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [1:0]  wd_type;
  logic [4:0]  addr;
  logic [31:0] alu_res, mem_data, wb_pc;
  logic [4:0]  ra1, ra2, dbg_addr;
  logic [31:0] rd1, rd2, dbg_data;
  logic        trc_valid;
  logic [31:0] trc_pc, trc_data, wr_count;
  logic [4:0]  trc_addr;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;
  logic        m_tv;
  logic [31:0] m_tpc, m_tdata;
  logic [4:0]  m_taddr;

  always #5 clk = ~clk;

  grf_wb dut (
    .clk(clk), .reset(reset), .we(we), .wd_type(wd_type), .addr(addr),
    .alu_res(alu_res), .mem_data(mem_data), .wb_pc(wb_pc),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .trc_valid(trc_valid), .trc_pc(trc_pc), .trc_addr(trc_addr),
    .trc_data(trc_data), .wr_count(wr_count)
  );

  function automatic logic m_commit(input logic w, input logic [1:0] t, input logic [4:0] a);
    return w && (a != 5'd0) && (t != 2'd3);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] t, input logic [31:0] alu,
                                          input logic [31:0] mem, input logic [31:0] pc);
    if (t == 2'd0) return alu;
    if (t == 2'd1) return mem;
    return pc + 32'd8;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_cnt = '0; m_tv = 1'b0; m_tpc = '0; m_tdata = '0; m_taddr = '0;
  endtask

  // One write-back cycle: drive, check combinational reads, clock, check state.
  task automatic cycle(input logic w, input logic [1:0] t, input logic [4:0] a,
                       input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
    logic        c;
    logic [31:0] wdat, e1, e2;
    we = w; wd_type = t; addr = a; alu_res = alu; mem_data = mem; wb_pc = pc;
    ra1 = r1; ra2 = r2; dbg_addr = dbg;
    #1;
    c    = m_commit(w, t, a);
    wdat = m_wdata(t, alu, mem, pc);
    e1 = (r1 == 0) ? 32'd0 : (c && r1 == a) ? wdat : m_regs[r1];
    e2 = (r2 == 0) ? 32'd0 : (c && r2 == a) ? wdat : m_regs[r2];
    checks++;
    if (rd1 !== e1) begin errors++; $display("FAIL rd1 ra1=%0d got %h want %h", r1, rd1, e1); end
    checks++;
    if (rd2 !== e2) begin errors++; $display("FAIL rd2 ra2=%0d got %h want %h", r2, rd2, e2); end
    checks++;
    if (dbg_data !== m_regs[dbg]) begin
      errors++; $display("FAIL dbg_pre addr=%0d got %h want %h", dbg, dbg_data, m_regs[dbg]);
    end
    @(posedge clk); #1;
    m_tv = c;
    if (c) begin
      m_regs[a] = wdat; m_cnt = m_cnt + 32'd1;
      m_tpc = pc; m_taddr = a; m_tdata = wdat;
    end
    checks++;
    if (trc_valid !== m_tv) begin errors++; $display("FAIL trc_valid got %b want %b", trc_valid, m_tv); end
    checks++;
    if (trc_pc !== m_tpc || trc_addr !== m_taddr || trc_data !== m_tdata) begin
      errors++;
      $display("FAIL trc_rec got %h/%0d/%h want %h/%0d/%h", trc_pc, trc_addr, trc_data, m_tpc, m_taddr, m_tdata);
    end
    checks++;
    if (wr_count !== m_cnt) begin errors++; $display("FAIL wr_count got %h want %h", wr_count, m_cnt); end
    checks++;
    if (dbg_data !== m_regs[dbg]) begin
      errors++; $display("FAIL dbg_post addr=%0d got %h want %h", dbg, dbg_data, m_regs[dbg]);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; we = 0; wd_type = 0; addr = 0; alu_res = 0; mem_data = 0; wb_pc = 0;
    ra1 = 0; ra2 = 0; dbg_addr = 0;
    model_clear();
    #2;
    // try a write during reset: must be ignored
    we = 1; addr = 5'd4; alu_res = 32'hAAAA5555; ra1 = 5'd4; dbg_addr = 5'd4;
    #1;
    checks++;
    if (rd1 !== 32'd0) begin errors++; $display("FAIL reset_bypass got %h want 0", rd1); end
    @(posedge clk); #1;
    checks++;
    if (trc_valid !== 1'b0 || wr_count !== 32'd0 || trc_pc !== 32'd0 || trc_addr !== 5'd0 || trc_data !== 32'd0) begin
      errors++; $display("FAIL reset_state got v=%b cnt=%h want 0", trc_valid, wr_count);
    end
    checks++;
    if (dbg_data !== 32'd0) begin errors++; $display("FAIL reset_write got %h want 0", dbg_data); end
    we = 0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_scenarios();
    // ALU write to r5, read back through rd1 after the edge
    cycle(1, 2'd0, 5'd5, 32'h12345678, 32'h0, 32'h100, 5'd0, 5'd0, 5'd5);
    cycle(0, 2'd0, 5'd0, 32'h0, 32'h0, 32'h0, 5'd5, 5'd0, 5'd5);
    checks++;
    if (rd1 !== 32'h12345678) begin errors++; $display("FAIL scen_alu got %h want 12345678", rd1); end
    // link write to r31
    cycle(1, 2'd2, 5'd31, 32'h0, 32'h0, 32'h00003000, 5'd0, 5'd0, 5'd31);
    checks++;
    if (trc_data !== 32'h00003008 || trc_addr !== 5'd31 || dbg_data !== 32'h00003008) begin
      errors++; $display("FAIL scen_link got %h/%h want 00003008", trc_data, dbg_data);
    end
    // write to r0 discarded
    cycle(1, 2'd0, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    checks++;
    if (trc_valid !== 1'b0 || wr_count !== 32'd2) begin
      errors++; $display("FAIL scen_r0 got v=%b cnt=%h want 0/2", trc_valid, wr_count);
    end
    // reserved source discarded
    cycle(1, 2'd3, 5'd9, 32'h11, 32'h22, 32'h33, 5'd9, 5'd9, 5'd9);
    // memory write to r8 with same-cycle bypass on rd2; dbg shows the old value
    cycle(1, 2'd1, 5'd8, 32'h0, 32'h0BADF00D, 32'h0, 5'd0, 5'd0, 5'd8);
    cycle(1, 2'd1, 5'd8, 32'h0, 32'hDEADBEEF, 32'h0, 5'd8, 5'd8, 5'd8);
    checks++;
    if (dbg_data !== 32'hDEADBEEF || trc_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL scen_mem got %h want deadbeef", dbg_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      cycle(1, 2'd0, 5'd12, 32'h1000 + 32'(i), 32'h0, 32'h40 + 32'(i), 5'd12, 5'd12, 5'd12);
    cycle(0, 2'd0, 5'd12, 32'h0, 32'h0, 32'h0, 5'd12, 5'd3, 5'd12);
    checks++;
    if (rd1 !== 32'h1003) begin errors++; $display("FAIL b2b_last got %h want 00001003", rd1); end
  endtask

  task automatic test_random();
    logic [4:0] a;
    for (int i = 0; i < 300; i++) begin
      a = 5'($urandom_range(0, 31));
      cycle(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), a,
            $urandom, $urandom, $urandom,
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31)),
            5'($urandom_range(0, 31)));
    end
  endtask

  task automatic test_wrap();
    force dut.wr_count_q = 32'hFFFFFFFF;
    #1;
    release dut.wr_count_q;
    m_cnt = 32'hFFFFFFFF;
    checks++;
    if (wr_count !== 32'hFFFFFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffffffff", wr_count); end
    cycle(1, 2'd0, 5'd7, 32'h77, 32'h0, 32'h0, 5'd7, 5'd0, 5'd7);
    checks++;
    if (wr_count !== 32'd0) begin errors++; $display("FAIL wrap got %h want 0", wr_count); end
  endtask

  task automatic test_reset_mid();
    cycle(1, 2'd0, 5'd3, 32'h33333333, 32'h0, 32'h300, 5'd0, 5'd0, 5'd3);
    // pending commit to r3, then reset between edges
    we = 1; wd_type = 2'd1; addr = 5'd3; mem_data = 32'h5A5A5A5A; ra1 = 5'd3; ra2 = 5'd3;
    #1;
    reset = 1'b0;
    #1;
    model_clear();
    checks++;
    if (rd1 !== 32'd0 || rd2 !== 32'd0) begin errors++; $display("FAIL rst_mid_rd got %h/%h want 0", rd1, rd2); end
    checks++;
    if (trc_valid !== 1'b0 || trc_pc !== 32'd0 || trc_addr !== 5'd0 || trc_data !== 32'd0 || wr_count !== 32'd0) begin
      errors++; $display("FAIL rst_mid_trc got v=%b pc=%h cnt=%h want 0", trc_valid, trc_pc, wr_count);
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #0.1;
      checks++;
      if (dbg_data !== 32'd0) begin errors++; $display("FAIL rst_mid_reg%0d got %h want 0", i, dbg_data); end
    end
    @(posedge clk); #1;
    checks++;
    if (trc_valid !== 1'b0 || wr_count !== 32'd0) begin
      errors++; $display("FAIL rst_mid_pulse got v=%b cnt=%h want 0", trc_valid, wr_count);
    end
    @(negedge clk);
    reset = 1'b1;
    // first commit after release lands at the first rising edge
    cycle(1, 2'd0, 5'd3, 32'hCAFEF00D, 32'h0, 32'h500, 5'd3, 5'd0, 5'd3);
    checks++;
    if (dbg_data !== 32'hCAFEF00D || wr_count !== 32'd1) begin
      errors++; $display("FAIL rst_release got %h cnt=%h want cafef00d/1", dbg_data, wr_count);
    end
  endtask

  initial begin
    test_reset();
    test_scenarios();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

// File: doc/grf_wb.md
GRF_WB -- requirements
Module: grf_wb

Interface
REQ-001 Port `clk`: input, 1 bit; single clock; all state updates on rising edge.
REQ-002 Port `reset`: input, 1 bit; asynchronous, active-low; reset is asynchronous and active-low.
REQ-003 Port `we`: input, 1 bit; write enable from the write-back decoder.
REQ-004 Port `wd_type`: input, 2 bits; write-data source select: 0 ALU, 1 memory, 2 link (PC+8), 3 reserved.
REQ-005 Port `addr`: input, 5 bits; destination register index.
REQ-006 Port `alu_res`: input, 32 bits; ALU result.
REQ-007 Port `mem_data`: input, 32 bits; load data.
REQ-008 Port `wb_pc`: input, 32 bits; PC of the instruction in write-back.
REQ-009 Ports `ra1` and `ra2`: input, 5 bits each; read indices.
REQ-010 Ports `rd1` and `rd2`: output, 32 bits each; read data.
REQ-011 Port `dbg_addr`: input, 5 bits; debug read index.
REQ-012 Port `dbg_data`: output, 32 bits; debug read data, no bypass.
REQ-013 Port `trc_valid`: output, 1 bit; registered commit-trace strobe.
REQ-014 Ports `trc_pc`, `trc_addr`, `trc_data`: output, 32, 5 and 32 bits; registered commit record.
REQ-015 Port `wr_count`: output, 32 bits; count of committed writes.

Function
REQ-016 Write data SHALL be: alu_res when wd_type=0, mem_data when 1, and wb_pc+8 when 2 (modulo 2^32).
REQ-017 A commit SHALL occur on a rising edge when we=1, addr!=0 and wd_type!=3; the write lands in reg[addr] at that edge.
REQ-018 When we=1 with addr=0 or wd_type=3, the write SHALL be discarded: no state change, no trace, no count.
REQ-019 reg[0] SHALL read 0 on every port at all times.
REQ-020 rd1/rd2 SHALL be combinational from ra1/ra2.
REQ-021 Internal bypass: when a commit is pending this cycle and raN==addr!=0, rdN SHALL return the pending write data.
REQ-022 Two reads of the same index SHALL return identical data, including under bypass.
REQ-023 dbg_data SHALL return stored contents only; the value written at an edge is visible after that edge.
REQ-024 The trace SHALL be registered with 1-cycle latency: after a commit edge, trc_valid=1 and trc_pc/addr/data hold the committed values for exactly one cycle.
REQ-025 trc_valid SHALL be 0 in cycles after an edge with no commit; trc_pc/addr/data hold their previous values.
REQ-026 wr_count SHALL increment by 1 per commit and wrap from 0xFFFFFFFF to 0.
REQ-027 Back-to-back commits to the same register: the last one wins; each commit produces its own trace pulse.

Reset
REQ-028 Asserting reset low SHALL immediately clear all 31 registers, trc_valid, trc_pc, trc_addr, trc_data and wr_count to 0, regardless of clk.
REQ-029 During reset, rd1/rd2/dbg_data SHALL read 0; bypass SHALL be suppressed and writes ignored.
REQ-030 After reset is released, the first commit SHALL take effect at the first rising edge with reset=1.
REQ-031 Reset asserted mid-operation SHALL drop any in-flight trace record; no pulse is emitted for the cancelled cycle.

Structure
REQ-032 A shared package SHALL hold the wd_type encodings (WD_ALU=0, WD_MEM=1, WD_LINK=2), the link offset of 8, and the register count of 32.
REQ-033 The write-data mux SHALL be a sub-module named `wd_mux`; storage, bypass, trace and counter logic stay in grf_wb.

Verification
REQ-034 Scenario: we=1, wd_type=0, addr=5, alu_res=0x12345678 -> after the edge, rd1 (ra1=5) reads 0x12345678; next cycle trc_valid=1, trc_addr=5, wr_count=1.
REQ-035 Scenario: we=1, wd_type=2, addr=31, wb_pc=0x00003000 -> reg[31]=0x00003008; trc_data=0x00003008.
REQ-036 Scenario: we=1, addr=0, alu_res=0xFFFFFFFF -> rd1 (ra1=0) reads 0; no trace pulse; wr_count unchanged.
REQ-037 Scenario: same-cycle write of addr=8 with mem_data=0xDEADBEEF and ra2=8 -> rd2=0xDEADBEEF before the edge; dbg_data (dbg_addr=8) reads the old value until the edge.
REQ-038 Scenario: wr_count preloaded near wrap (0xFFFFFFFF) via 2^32-1 commits or a force, then one more commit -> wr_count=0.
REQ-039 Scenario: reset pulled low between edges after several writes -> all registers, trace outputs and wr_count read 0 immediately; a pending trace pulse is suppressed.
